// File: rtl/mac_vec_pair.sv
// -----------------------------------------------------------------------------
// mac_vec_pair
//
// Multi-lane integer multiply-accumulate engine. Two independently handshaked
// operand vectors (A and B) are each captured into a one-deep holding
// register. While RUN is active, every cycle in which both holds are full
// "fires" a pair: the operands move into a pipeline that multiplies them per
// lane (one edge later) and adds the product into a per-lane accumulator
// (two edges later). After the configured number of pairs has fired, the
// engine drains the pipeline and presents one result vector for a single
// cycle.
//
// Optional build macro:
//   MAC_SAT_EN  - when defined, each lane result clamps to the OUT_W range of
//                 the latched mode and sat_flag reports which lanes clamped.
//                 When undefined, results wrap (low OUT_W accumulator bits)
//                 and sat_flag is held at zero.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   config_en   one-cycle pulse; latches data_num and int_signed when IDLE
//   int_signed  1 = two's-complement operands/result, 0 = unsigned
//   data_num    products per lane to accumulate per result (0 is rejected)
//   in_a        operand A vector, lane i at [i*DATA_W +: DATA_W]
//   in_valid_a  in_a valid
//   in_ready_a  in_a accepted on valid && ready at a rising edge
//   in_b        operand B vector, same packing as in_a
//   in_valid_b  in_b valid
//   in_ready_b  in_b accepted on valid && ready at a rising edge
//   mac_out     result vector, lane i at [i*OUT_W +: OUT_W]
//   out_valid   one-cycle pulse, mac_out/sat_flag valid (no backpressure)
//   sat_flag    per-lane saturation indicator
//   busy        high while RUN or DRAIN
//   cfg_err     one-cycle pulse when a config request is rejected
// -----------------------------------------------------------------------------
module mac_vec_pair #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    config_en,
  input  logic                    int_signed,
  input  logic [CNT_W-1:0]        data_num,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic                    in_valid_a,
  output logic                    in_ready_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  input  logic                    in_valid_b,
  output logic                    in_ready_b,
  output logic [LANES*OUT_W-1:0]  mac_out,
  output logic                    out_valid,
  output logic [LANES-1:0]        sat_flag,
  output logic                    busy,
  output logic                    cfg_err
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int VEC_W  = LANES * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Per-lane arithmetic helpers
  // ---------------------------------------------------------------------------

  // Both operands are extended to the product width according to the mode;
  // the low PROD_W bits of the wide product are then correct for either mode.
  function automatic logic [PROD_W-1:0] lane_mul(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              sgn
  );
    logic [PROD_W-1:0] ea;
    logic [PROD_W-1:0] eb;
    if (sgn) begin
      ea = {{DATA_W{a[DATA_W-1]}}, a};
      eb = {{DATA_W{b[DATA_W-1]}}, b};
    end else begin
      ea = {{DATA_W{1'b0}}, a};
      eb = {{DATA_W{1'b0}}, b};
    end
    return ea * eb;
  endfunction

  // Sign- or zero-extend a lane product to accumulator width.
  function automatic logic [ACC_W-1:0] lane_ext(
    input logic [PROD_W-1:0] p,
    input logic              sgn
  );
    logic [ACC_W-1:0] r;
    if (sgn) begin
      r = {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    end else begin
      r = {{(ACC_W-PROD_W){1'b0}}, p};
    end
    return r;
  endfunction

`ifdef MAC_SAT_EN
  // Clamp an accumulator to the OUT_W range of the mode; the MSB of the
  // returned value is the saturation flag.
  function automatic logic [OUT_W:0] lane_sat(
    input logic [ACC_W-1:0] acc,
    input logic             sgn
  );
    logic [OUT_W:0] r;
    if (sgn) begin
      // Fits when every bit from OUT_W-1 upward equals the sign bit.
      if (acc[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){acc[ACC_W-1]}}) begin
        r = {1'b0, acc[OUT_W-1:0]};
      end else if (acc[ACC_W-1]) begin
        r = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        r = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
      end
    end else begin
      if (acc[ACC_W-1:OUT_W] == {(ACC_W-OUT_W){1'b0}}) begin
        r = {1'b0, acc[OUT_W-1:0]};
      end else begin
        r = {1'b1, {OUT_W{1'b1}}};
      end
    end
    return r;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          rem_q, rem_d;
  logic                      mode_q, mode_d;

  logic                      hold_a_q, hold_a_d;
  logic                      hold_b_q, hold_b_d;
  logic [VEC_W-1:0]          a_q, a_d;
  logic [VEC_W-1:0]          b_q, b_d;

  logic [VEC_W-1:0]          op_a_q, op_a_d;
  logic [VEC_W-1:0]          op_b_q, op_b_d;
  logic                      v0_q, v0_d;
  logic                      v1_q, v1_d;
  logic                      last0_q, last0_d;
  logic                      last1_q, last1_d;
  logic                      last2_q, last2_d;
  logic [LANES*PROD_W-1:0]   prod_q, prod_d;
  logic [LANES*ACC_W-1:0]    acc_q, acc_d;

  logic [LANES*OUT_W-1:0]    mac_out_q, mac_out_d;
  logic [LANES-1:0]          sat_q, sat_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;
  logic                      cfg_err_q, cfg_err_d;

  logic                      fire_s;
  logic                      take_a_s;
  logic                      take_b_s;
  logic                      cfg_ok_s;
  logic                      cfg_bad_s;
  logic                      last_fire_s;

  // Handshake and control decode.
  always_comb begin
    fire_s      = (state_q == ST_RUN) && hold_a_q && hold_b_q;
    in_ready_a  = !hold_a_q || fire_s;
    in_ready_b  = !hold_b_q || fire_s;
    take_a_s    = in_valid_a && in_ready_a;
    take_b_s    = in_valid_b && in_ready_b;
    cfg_ok_s    = config_en && (state_q == ST_IDLE) && (data_num != {CNT_W{1'b0}});
    cfg_bad_s   = config_en && !cfg_ok_s;
    last_fire_s = fire_s && (rem_q == CNT_W'(1));
  end

  // FSM next state, remaining count and latched mode.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_ok_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_fire_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Final product has reached the accumulator; result leaves this edge.
        if (last2_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (cfg_ok_s) begin
      rem_d  = data_num;
      mode_d = int_signed;
    end else if (fire_s) begin
      rem_d  = rem_q - CNT_W'(1);
      mode_d = mode_q;
    end else begin
      rem_d  = rem_q;
      mode_d = mode_q;
    end
  end

  // Operand holding registers; a refill at the fire edge keeps the hold full.
  always_comb begin
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    a_d      = a_q;
    b_d      = b_q;
    if (take_a_s) begin
      hold_a_d = 1'b1;
      a_d      = in_a;
    end else if (fire_s) begin
      hold_a_d = 1'b0;
    end else begin
      hold_a_d = hold_a_q;
    end
    if (take_b_s) begin
      hold_b_d = 1'b1;
      b_d      = in_b;
    end else if (fire_s) begin
      hold_b_d = 1'b0;
    end else begin
      hold_b_d = hold_b_q;
    end
  end

  // Datapath pipeline: fire -> operand stage -> product -> accumulate.
  always_comb begin
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    v0_d    = fire_s;
    v1_d    = v0_q;
    last0_d = last_fire_s;
    last1_d = last0_q;
    last2_d = last1_q;
    if (fire_s) begin
      op_a_d = a_q;
      op_b_d = b_q;
    end else begin
      op_a_d = op_a_q;
    end
    if (v0_q) begin
      for (int i = 0; i < LANES; i++) begin
        prod_d[i*PROD_W +: PROD_W] = lane_mul(op_a_q[i*DATA_W +: DATA_W],
                                              op_b_q[i*DATA_W +: DATA_W], mode_q);
      end
    end else begin
      prod_d = prod_q;
    end
    // Config and accumulate never coincide: config is only taken in IDLE,
    // when the pipeline is empty.
    if (cfg_ok_s) begin
      acc_d = {(LANES*ACC_W){1'b0}};
    end else if (v1_q) begin
      for (int i = 0; i < LANES; i++) begin
        acc_d[i*ACC_W +: ACC_W] = acc_q[i*ACC_W +: ACC_W]
                                + lane_ext(prod_q[i*PROD_W +: PROD_W], mode_q);
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Registered outputs: result formatting, status pulses and busy.
  always_comb begin
    mac_out_d   = mac_out_q;
    sat_d       = sat_q;
    out_valid_d = last2_q;
    busy_d      = (state_d != ST_IDLE);
    cfg_err_d   = cfg_bad_s;
    if (last2_q) begin
      for (int i = 0; i < LANES; i++) begin
`ifdef MAC_SAT_EN
        {sat_d[i], mac_out_d[i*OUT_W +: OUT_W]} = lane_sat(acc_q[i*ACC_W +: ACC_W], mode_q);
`else
        mac_out_d[i*OUT_W +: OUT_W] = acc_q[i*ACC_W +: ACC_W - (ACC_W - OUT_W)];
        sat_d[i]                    = 1'b0;
`endif
      end
    end else begin
      mac_out_d = mac_out_q;
      sat_d     = sat_q;
    end
  end

  // Control and operand-hold state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= {CNT_W{1'b0}};
      mode_q   <= 1'b0;
      hold_a_q <= 1'b0;
      hold_b_q <= 1'b0;
      a_q      <= {VEC_W{1'b0}};
      b_q      <= {VEC_W{1'b0}};
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  // Pipeline and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q  <= {VEC_W{1'b0}};
      op_b_q  <= {VEC_W{1'b0}};
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      prod_q  <= {(LANES*PROD_W){1'b0}};
      acc_q   <= {(LANES*ACC_W){1'b0}};
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      last2_q <= last2_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_out_q   <= {(LANES*OUT_W){1'b0}};
      sat_q       <= {LANES{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      mac_out_q   <= mac_out_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign mac_out   = mac_out_q;
  assign sat_flag  = sat_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_mac_vec_pair.sv
// -----------------------------------------------------------------------------
// tb_mac_vec_pair
//
// Scoreboard bench for mac_vec_pair. Each issued job pushes its expected
// result (computed with plain integer arithmetic over the operand pairs) into
// a queue; a monitor pops and compares whenever out_valid is seen. Directed
// cases cover the basic accumulate, saturation/wrap, signed vs unsigned,
// rejected configs, A/B skew and reset mid-run; randomized jobs follow.
// -----------------------------------------------------------------------------
module tb_mac_vec_pair;

  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam int OUT_W  = 16;
  localparam int CNT_W  = 16;
  localparam int VW     = LANES * DATA_W;
  localparam int OW     = LANES * OUT_W;

  logic             clk;
  logic             rst;
  logic             config_en;
  logic             int_signed;
  logic [CNT_W-1:0] data_num;
  logic [VW-1:0]    in_a;
  logic             in_valid_a;
  logic             in_ready_a;
  logic [VW-1:0]    in_b;
  logic             in_valid_b;
  logic             in_ready_b;
  logic [OW-1:0]    mac_out;
  logic             out_valid;
  logic [LANES-1:0] sat_flag;
  logic             busy;
  logic             cfg_err;

  mac_vec_pair #(
    .LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .config_en(config_en), .int_signed(int_signed),
    .data_num(data_num),
    .in_a(in_a), .in_valid_a(in_valid_a), .in_ready_a(in_ready_a),
    .in_b(in_b), .in_valid_b(in_valid_b), .in_ready_b(in_ready_b),
    .mac_out(mac_out), .out_valid(out_valid), .sat_flag(sat_flag),
    .busy(busy), .cfg_err(cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int nout  = 0;
  int njobs = 0;
  int out_cyc = 0;

  logic [VW-1:0]    ja[$];
  logic [VW-1:0]    jb[$];
  logic [OW-1:0]    exp_res[$];
  logic [LANES-1:0] exp_sat[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: integer dot product per lane, then clamp or wrap to OUT_W.
  task automatic model(input bit sgn, output logic [OW-1:0] res, output logic [LANES-1:0] sat);
    for (int l = 0; l < LANES; l++) begin
      longint sum;
      longint x;
      longint y;
      longint lo;
      longint hi;
      logic [63:0] bits;
      sum = 0;
      for (int k = 0; k < ja.size(); k++) begin
        x = longint'(ja[k][l*DATA_W +: DATA_W]);
        y = longint'(jb[k][l*DATA_W +: DATA_W]);
        if (sgn && x >= (longint'(1) <<< (DATA_W-1))) x = x - (longint'(1) <<< DATA_W);
        if (sgn && y >= (longint'(1) <<< (DATA_W-1))) y = y - (longint'(1) <<< DATA_W);
        sum = sum + x * y;
      end
      sat[l] = 1'b0;
`ifdef MAC_SAT_EN
      if (sgn) begin
        lo = -(longint'(1) <<< (OUT_W-1));
        hi = (longint'(1) <<< (OUT_W-1)) - 1;
      end else begin
        lo = 0;
        hi = (longint'(1) <<< OUT_W) - 1;
      end
      if (sum > hi) begin sum = hi; sat[l] = 1'b1; end
      else if (sum < lo) begin sum = lo; sat[l] = 1'b1; end
`else
      lo = 0;
      hi = 0;
`endif
      bits = 64'(sum);
      res[l*OUT_W +: OUT_W] = bits[OUT_W-1:0];
    end
  endtask

  function automatic logic [VW-1:0] lane0(input logic [DATA_W-1:0] v);
    logic [VW-1:0] r;
    r = '0;
    r[DATA_W-1:0] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] r;
    for (int l = 0; l < LANES; l++) begin
      case ($urandom_range(5, 0))
        0:       r[l*DATA_W +: DATA_W] = 16'h7FFF;
        1:       r[l*DATA_W +: DATA_W] = 16'h8000;
        2:       r[l*DATA_W +: DATA_W] = 16'hFFFF;
        default: r[l*DATA_W +: DATA_W] = DATA_W'($urandom);
      endcase
    end
    return r;
  endfunction

  // Config pulse; when push is set the job's expected result is queued.
  task automatic start_job(input bit sgn, input int n, input bit push);
    logic [OW-1:0]    r;
    logic [LANES-1:0] s;
    config_en  = 1'b1;
    int_signed = sgn;
    data_num   = CNT_W'(n);
    if (push) begin
      model(sgn, r, s);
      exp_res.push_back(r);
      exp_sat.push_back(s);
      njobs++;
    end
    @(negedge clk);
    config_en  = 1'b0;
    int_signed = 1'($urandom);
    data_num   = CNT_W'($urandom);
    chk("cfg_err_on_good_cfg", 64'(cfg_err), 64'd0);
  endtask

  task automatic send_a(input int lead, input int gapmax);
    repeat (lead) @(negedge clk);
    for (int k = 0; k < ja.size(); k++) begin
      int g;
      bit ok;
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      if (g > 0) begin
        in_valid_a = 1'b0;
        repeat (g) @(negedge clk);
      end
      in_a = ja[k];
      in_valid_a = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
        ok = in_ready_a;
        @(negedge clk);
      end
      if (!ok) begin
        n_cmp++; n_err++;
        $display("FAIL a_handshake_timeout: ready never seen, expected accept");
      end
    end
    in_valid_a = 1'b0;
    in_a = rnd_vec();
  endtask

  task automatic send_b(input int lead, input int gapmax);
    repeat (lead) @(negedge clk);
    for (int k = 0; k < jb.size(); k++) begin
      int g;
      bit ok;
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      if (g > 0) begin
        in_valid_b = 1'b0;
        repeat (g) @(negedge clk);
      end
      in_b = jb[k];
      in_valid_b = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
        ok = in_ready_b;
        @(negedge clk);
      end
      if (!ok) begin
        n_cmp++; n_err++;
        $display("FAIL b_handshake_timeout: ready never seen, expected accept");
      end
    end
    in_valid_b = 1'b0;
    in_b = rnd_vec();
  endtask

  task automatic stream(input int la, input int lb, input int gap);
    fork
      send_a(la, gap);
      send_b(lb, gap);
    join
  endtask

  task automatic wait_done();
    for (int t = 0; t < 300 && nout < njobs; t++) @(negedge clk);
    chk("result_count", 64'(nout), 64'(njobs));
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      nout++;
      out_cyc = cyc;
      if (exp_res.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_out_valid: got out_valid=1 mac_out=0x%0h expected no result", mac_out);
      end else begin
        chk("mac_out", 64'(mac_out), 64'(exp_res.pop_front()));
        chk("sat_flag", 64'(sat_flag), 64'(exp_sat.pop_front()));
        chk("busy_with_out_valid", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    int c0;
    rst = 1'b1;
    config_en = 1'b0; int_signed = 1'b0; data_num = '0;
    in_a = '0; in_b = '0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mac_out", 64'(mac_out), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sat_flag", 64'(sat_flag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_ready_a", 64'(in_ready_a), 64'd1);
    chk("rst_ready_b", 64'(in_ready_b), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Basic accumulate with latency check: last fire 3 edges before result.
    ja = {lane0(16'd2), lane0(16'd4), lane0(16'hFFFF)};
    jb = {lane0(16'd3), lane0(16'd5), lane0(16'd7)};
    start_job(1'b1, 3, 1'b1);
    c0 = cyc;
    chk("busy_after_cfg", 64'(busy), 64'd1);
    stream(0, 0, 0);
    wait_done();
    chk("basic_latency", 64'(out_cyc - c0), 64'd7);
    @(negedge clk);
    chk("out_valid_one_cycle", 64'(out_valid), 64'd0);

    // Overflow: 0x7FFF*0x7FFF twice.
    ja = {lane0(16'h7FFF), lane0(16'h7FFF)};
    jb = {lane0(16'h7FFF), lane0(16'h7FFF)};
    start_job(1'b1, 2, 1'b1);
    stream(0, 0, 0);
    wait_done();

    // Signed vs unsigned interpretation of 0xFFFF * 2.
    ja = {lane0(16'hFFFF)};
    jb = {lane0(16'h0002)};
    start_job(1'b0, 1, 1'b1);
    stream(0, 0, 0);
    wait_done();
    start_job(1'b1, 1, 1'b1);
    stream(0, 0, 0);
    wait_done();

    // Rejected config in IDLE.
    config_en = 1'b1; data_num = '0;
    @(negedge clk);
    config_en = 1'b0;
    chk("cfg_err_zero_num", 64'(cfg_err), 64'd1);
    chk("busy_zero_num", 64'(busy), 64'd0);
    @(negedge clk);
    chk("cfg_err_pulse_end", 64'(cfg_err), 64'd0);
    chk("busy_zero_num_late", 64'(busy), 64'd0);

    // Rejected config mid-run must not disturb count or result.
    ja = {rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec()};
    jb = {rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec()};
    start_job(1'b1, 4, 1'b1);
    fork
      stream(0, 0, 0);
      begin
        repeat (2) @(negedge clk);
        config_en = 1'b1; data_num = CNT_W'(1); int_signed = 1'b0;
        @(negedge clk);
        config_en = 1'b0;
        chk("cfg_err_mid_run", 64'(cfg_err), 64'd1);
        @(negedge clk);
        chk("cfg_err_mid_run_end", 64'(cfg_err), 64'd0);
      end
    join
    wait_done();

    // Skew: same pairs without and with B trailing A by 4 cycles.
    ja = {rnd_vec(), rnd_vec(), rnd_vec()};
    jb = {rnd_vec(), rnd_vec(), rnd_vec()};
    start_job(1'b0, 3, 1'b1);
    stream(0, 0, 0);
    wait_done();
    start_job(1'b0, 3, 1'b1);
    fork
      stream(0, 4, 0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("skew_ready_a_low", 64'(in_ready_a), 64'd0);
        end
      end
    join
    wait_done();

    // Randomized jobs with gaps, skew and occasional pre-loading in IDLE.
    for (int j = 0; j < 12; j++) begin
      int n;
      bit sgn;
      int r;
      n = int'($urandom_range(8, 1));
      sgn = 1'($urandom);
      r = int'($urandom_range(3, 0));
      ja = {};
      jb = {};
      for (int k = 0; k < n; k++) begin
        ja.push_back(rnd_vec());
        jb.push_back(rnd_vec());
      end
      fork
        stream(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 2);
        begin
          repeat (r) @(negedge clk);
          start_job(sgn, n, 1'b1);
        end
      join
      wait_done();
    end

    // Reset mid-run after two fires: nothing may come out of the aborted job.
    ja = {rnd_vec(), rnd_vec()};
    jb = {rnd_vec(), rnd_vec()};
    start_job(1'b1, 5, 1'b0);
    stream(0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_mac_out", 64'(mac_out), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_sat", 64'(sat_flag), 64'd0);
    chk("midrst_ready_a", 64'(in_ready_a), 64'd1);
    chk("midrst_ready_b", 64'(in_ready_b), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_no_output", 64'(nout), 64'(njobs));
    ja = {lane0(16'd3)};
    jb = {lane0(16'd4)};
    start_job(1'b1, 1, 1'b1);
    stream(0, 0, 0);
    wait_done();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_res.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_vec_pair.md
Name: mac_vec_pair

Overview:
- Parametrised multi-lane integer multiply-accumulate engine; next generation of the single-lane mac.
- Accepts independently-validated A and B operand vectors with skew tolerance and backpressure.
- Accumulates a configured number of products per lane, then emits one saturated result vector.
- Sits between the operand streamers and the result writer in the MAC datapath.

Parameters:
LANES, 4, number of parallel MAC lanes
DATA_W, 16, operand width per lane
ACC_W, 40, accumulator width per lane; must be >= 2*DATA_W+1
OUT_W, 16, result width per lane
CNT_W, 16, width of the data_num term counter

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  reset, asynchronous, active-high
config_en  in  1  single-cycle pulse; latches data_num and int_signed
int_signed  in  1  1 = two's-complement operands/result, 0 = unsigned
data_num  in  CNT_W  products per lane to accumulate per result
in_a  in  LANES*DATA_W  operand A, lane i at bits [i*DATA_W +: DATA_W]
in_valid_a  in  1  in_a valid
in_ready_a  out  1  in_a accepted when valid&&ready at rising edge
in_b  in  LANES*DATA_W  operand B, same packing
in_valid_b  in  1  in_b valid
in_ready_b  out  1  in_b accepted when valid&&ready
mac_out  out  LANES*OUT_W  result vector, lane i at [i*OUT_W +: OUT_W]
out_valid  out  1  one-cycle pulse, mac_out valid
sat_flag  out  LANES  per-lane saturation indicator, valid with out_valid
busy  out  1  high in RUN and DRAIN
cfg_err  out  1  one-cycle pulse on rejected config

Behaviour:
- Reset: all outputs 0 except in_ready_a/in_ready_b, which are 1. Holding registers are empty, accumulators are 0, and the state is IDLE.
- Reset mid-operation discards all partial accumulation and held operands.
- FSM IDLE->RUN: config_en with data_num!=0 latches data_num into the remaining-count register and latches int_signed. Accumulators clear at the same edge.
- Config rejections: config_en with data_num==0 in IDLE, or config_en in RUN/DRAIN, is ignored and raises cfg_err for one cycle.
- Operand capture:
  - Each operand has a one-deep holding register.
  - in_ready_x = !hold_x || fire.
  - Operands are accepted in IDLE as well, so they can be pre-loaded.
  - Skew between A and B is unbounded.
- Pair fire: fire = (state==RUN) && hold_a && hold_b. Both holds clear at the fire edge unless refilled at the same edge (simultaneous accept and fire is legal). Each fire decrements the remaining count.
- Pipeline:
  - Fire edge t: per-lane product registered at t+1; width 2*DATA_W, signed or unsigned per int_signed.
  - Product added into the accumulator at t+2, sign- or zero-extended to ACC_W.
- RUN->DRAIN: at the fire edge that takes the remaining count from 1 to 0. No further fires occur in DRAIN; arriving operands stay held.
- DRAIN->IDLE: at edge t_last+3, out_valid pulses for one cycle with registered mac_out and sat_flag. Accumulators hold their values until the next accepted config.
- Throughput: one pair per cycle when both streams are continuously valid.
- Accumulator overflow beyond ACC_W wraps silently. Sizing ACC_W is the integrator's responsibility.
- out_valid has no backpressure; the consumer must take the result in that cycle.

Optional Feature:
- MAC_SAT_EN defined:
  - Each lane's result clamps to the OUT_W range for the latched mode.
  - Signed range: [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Unsigned range: [0, 2^OUT_W-1].
  - sat_flag[i]=1 when lane i clamped.
- MAC_SAT_EN undefined:
  - mac_out lane = acc[OUT_W-1:0] (wrap).
  - sat_flag tied to 0.

Test Plan:
- Basic accumulate: int_signed=1, data_num=3; lane0 pairs (2,3),(4,5),(-1,7); other lanes 0 -> lane0=19 (0x0013), other lanes 0, out_valid exactly one cycle at 3 edges after the third fire, busy falls with out_valid.
- Skew: in_a valid 4 cycles before in_b -> in_ready_a low after the first A accept until fire; results match the no-skew run; no operand is lost or duplicated.
- Overflow: int_signed=1, data_num=2, lane0 0x7FFF*0x7FFF twice (acc 0x7FFE0002) -> MAC_SAT_EN: 0x7FFF with sat_flag[0]=1; without: 0x0002 with sat_flag=0.
- Signed vs unsigned: data_num=1, 0xFFFF*0x0002 -> int_signed=0: acc 0x1FFFE, result 0xFFFF (MAC_SAT_EN) or 0xFFFE (wrap); int_signed=1: -2, result 0xFFFE, sat_flag=0.
- Config errors: config_en with data_num=0 in IDLE -> cfg_err pulse, busy stays 0; config_en mid-RUN -> cfg_err pulse, remaining count and result unaffected.
- Reset mid-run: data_num=5, assert rst after 2 fires -> outputs 0, in_ready high, no out_valid; a subsequent data_num=1 (3,4) run yields 12 with no residue.
